// File: rtl/cnn_argmax_if.sv
// Stream and handshake bundle for the CNN argmax classifier.
// The margin signal exists only when CNN_ARGMAX_MARGIN_EN is defined.
interface cnn_argmax_if #(
  parameter int unsigned LOGIT_W = 16,
  parameter int unsigned CLASS_W = 4
);
  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic [LOGIT_W-1:0]   in_data;
  logic                 in_last;
  logic                 busy;
  logic                 done;
  logic [CLASS_W-1:0]   predicted_class;
  logic [LOGIT_W-1:0]   max_logit;
  logic                 err;
`ifdef CNN_ARGMAX_MARGIN_EN
  logic [LOGIT_W:0]     margin;
`endif

  modport master (
    output start, in_valid, in_data, in_last,
    input  in_ready, busy, done, predicted_class, max_logit, err
`ifdef CNN_ARGMAX_MARGIN_EN
    , input margin
`endif
  );

  modport slave (
    input  start, in_valid, in_data, in_last,
    output in_ready, busy, done, predicted_class, max_logit, err
`ifdef CNN_ARGMAX_MARGIN_EN
    , output margin
`endif
  );
endinterface

// File: rtl/cnn_argmax_classifier.sv
// Streaming argmax over signed logits with frame-length error checking.
// Optional CNN_ARGMAX_MARGIN_EN adds a top-1 minus top-2 margin output.
module cnn_argmax_classifier #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned LOGIT_W     = 16,
  parameter int unsigned CLASS_W     = 4
) (
  input logic         clk,
  input logic         rst,
  cnn_argmax_if.slave bus
);
  localparam int unsigned LAST_IDX = NUM_CLASSES - 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;
  state_t state, state_next;

  logic                      in_ready_q, busy_q, done_q, err_q;
  logic [CLASS_W-1:0]        class_q, cnt, run_idx;
  logic [LOGIT_W-1:0]        max_q;
  logic signed [LOGIT_W-1:0] run_max;
  logic                      have_max;

  logic                      xfer_c, final_c, at_last_c, take_c;
  logic signed [LOGIT_W-1:0] beat_c, new_max_c;
  logic [CLASS_W-1:0]        new_idx_c;

  assign beat_c    = $signed(bus.in_data);
  assign xfer_c    = bus.in_valid && in_ready_q;
  assign at_last_c = (cnt == CLASS_W'(LAST_IDX));
  assign final_c   = xfer_c && (bus.in_last || at_last_c);
  // Strictly-greater replacement keeps the lowest index on ties
  assign take_c    = !have_max || (beat_c > run_max);
  assign new_max_c = take_c ? beat_c : run_max;
  assign new_idx_c = take_c ? cnt : run_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.start) state_next = S_ACCUM;
      S_ACCUM: if (final_c)   state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      in_ready_q <= (state_next == S_ACCUM);
      busy_q     <= (state_next == S_ACCUM);
      done_q     <= (state_next == S_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      run_idx  <= '0;
      run_max  <= '0;
      have_max <= 1'b0;
      class_q  <= '0;
      max_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.start) begin
        cnt      <= '0;
        have_max <= 1'b0;
      end
      if (xfer_c) begin
        cnt      <= cnt + CLASS_W'(1);
        have_max <= 1'b1;
        run_max  <= new_max_c;
        run_idx  <= new_idx_c;
      end
      // Results are captured with the final beat so they are valid alongside done
      if (final_c) begin
        class_q <= new_idx_c;
        max_q   <= LOGIT_W'(new_max_c);
        err_q   <= (bus.in_last != at_last_c);
      end
    end
  end

`ifdef CNN_ARGMAX_MARGIN_EN
  logic signed [LOGIT_W-1:0] run_sec, new_sec_c;
  logic                      have_sec, new_have_sec_c;
  logic [LOGIT_W:0]          margin_q;

  // Second max: displaced top-1 or a beat beating the current runner-up
  always_comb begin
    new_sec_c      = run_sec;
    new_have_sec_c = have_sec;
    if (have_max) begin
      if (beat_c > run_max) begin
        new_sec_c      = run_max;
        new_have_sec_c = 1'b1;
      end else if (!have_sec || beat_c > run_sec) begin
        new_sec_c      = beat_c;
        new_have_sec_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_sec  <= '0;
      have_sec <= 1'b0;
      margin_q <= '0;
    end else begin
      if (state == S_IDLE && bus.start) have_sec <= 1'b0;
      if (xfer_c) begin
        run_sec  <= new_sec_c;
        have_sec <= new_have_sec_c;
      end
      if (final_c) begin
        margin_q <= new_have_sec_c
                    ? ({new_max_c[LOGIT_W-1], new_max_c} - {new_sec_c[LOGIT_W-1], new_sec_c})
                    : '0;
      end
    end
  end

  assign bus.margin = margin_q;
`endif

  assign bus.in_ready        = in_ready_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.predicted_class = class_q;
  assign bus.max_logit       = max_q;
  assign bus.err             = err_q;
endmodule

// File: tb/tb_cnn_argmax_classifier.sv
// Scoreboard bench for cnn_argmax_classifier: expected results queued at start, checked on done.
module tb_cnn_argmax_classifier;
  localparam int unsigned NUM_CLASSES = 10;
  localparam int unsigned LOGIT_W     = 16;
  localparam int unsigned CLASS_W     = 4;

  typedef struct {
    int cls;
    int mx;
    int err;
    int margin;
    int start_cyc;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  cnn_argmax_if #(.LOGIT_W(LOGIT_W), .CLASS_W(CLASS_W)) bus ();

  cnn_argmax_classifier #(
    .NUM_CLASSES(NUM_CLASSES), .LOGIT_W(LOGIT_W), .CLASS_W(CLASS_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint expv);
    checks++;
    if (obs != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: first index of the maximum; margin from a descending sort
  function automatic exp_t model(input int v[$], input int n, input bit last_flag);
    exp_t e;
    int   s[$];
    e.cls = 0;
    e.mx  = v[0];
    for (int i = 0; i < n; i++) begin
      s.push_back(v[i]);
      if (v[i] > e.mx) begin
        e.mx  = v[i];
        e.cls = i;
      end
    end
    s.rsort();
    e.margin    = (n > 1) ? (s[0] - s[1]) : 0;
    e.err       = last_flag ? int'(n != NUM_CLASSES) : 1;
    e.start_cyc = 0;
    e.lat       = 0;
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    if (bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("predicted_class", int'(bus.predicted_class), e.cls);
        chk("max_logit", int'($signed(bus.max_logit)), e.mx);
        chk("err", int'(bus.err), e.err);
`ifdef CNN_ARGMAX_MARGIN_EN
        chk("margin", int'(bus.margin), e.margin);
`endif
        if (e.lat > 0) chk("latency", cyc - e.start_cyc, e.lat);
        chk("busy_at_done", int'(bus.busy), 0);
      end
    end
  end

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_beat(input int val, input bit last, input bit extra_start);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = LOGIT_W'(val);
    bus.in_last  = last;
    bus.start    = extra_start;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("ready_timeout", 0, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic run_frame(input int v[$], input int n, input bit last_flag,
                           input bit gaps, input int lat);
    exp_t e;
    e = model(v, n, last_flag);
    e.start_cyc = cyc;
    e.lat       = lat;
    sb.push_back(e);
    pulse_start();
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_beat(v[i], last_flag && (i == n - 1), gaps && (i == 3));
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"}, int'(bus.in_ready), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_class"}, int'(bus.predicted_class), 0);
    chk({tag, "_max"}, int'(bus.max_logit), 0);
    chk({tag, "_err"}, int'(bus.err), 0);
`ifdef CNN_ARGMAX_MARGIN_EN
    chk({tag, "_margin"}, int'(bus.margin), 0);
`endif
  endtask

  initial begin
    int f_basic[$] = '{3, -1, 7, 2, 0, 5, -8, 1, 6, 4};
    int f_neg[$]   = '{-5, -3, -9, -3, -20, -7, -4, -6, -8, -10};
    int f_short[$] = '{1, 9, 2, 3};
    int f_unterm[$] = '{-32768, 2, 3, 4, 5, 6, 7, 8, 9, 32767};
    int f_one[$]   = '{-7};
    int f_abort[$] = '{50, 60, 70, 80, 90, 100};
    int f_fresh[$] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run_frame(f_basic, 10, 1'b1, 1'b0, NUM_CLASSES + 1);
    wait_drain();
    run_frame(f_neg, 10, 1'b1, 1'b0, NUM_CLASSES + 1);
    wait_drain();
    run_frame(f_short, 4, 1'b1, 1'b0, 5);
    wait_drain();

    // Unterminated frame, then an 11th beat and IDLE beats must be refused
    run_frame(f_unterm, 10, 1'b0, 1'b0, NUM_CLASSES + 1);
    bus.in_valid = 1'b1;
    bus.in_data  = LOGIT_W'(123);
    chk("ready_11th_beat", int'(bus.in_ready), 0);
    repeat (3) begin
      @(negedge clk);
      chk("ready_idle", int'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    wait_drain();

    run_frame(f_one, 1, 1'b1, 1'b0, 2);
    wait_drain();
    run_frame(f_basic, 10, 1'b1, 1'b1, 0);
    wait_drain();

    // Abort mid-frame with reset: no done, all outputs cleared
    pulse_start();
    for (int i = 0; i < 6; i++) send_beat(f_abort[i], 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_done_after_rst", int'(bus.done), 0);
    run_frame(f_fresh, 10, 1'b1, 1'b0, NUM_CLASSES + 1);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
